// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: arbiter state encoding, default character format and
// line-rate constants reused by the transmitter, plus the round-robin wrap helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEND  = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } uart_state_t;

    localparam int UART_D_BITS       = 8;
    localparam int UART_CLK_HZ       = 100_000_000;
    localparam int UART_BAUD         = 921_600;
    localparam int UART_CLKS_PER_BIT = (UART_CLK_HZ + (UART_BAUD / 2)) / UART_BAUD;

    // Next pointer after index idx, wrapping explicitly so non-power-of-2 counts work.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        if ((idx + 32'd1) >= n) begin
            return 32'd0;
        end else begin
            return idx + 32'd1;
        end
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin first-one finder: scans req starting at ptr
// (ptr itself first) and wraps, returning the winner as one-hot and index.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [PW-1:0]    idx,
    output logic             any
);

    logic [PW:0] cand_s;

    // Priority scan from ptr upward with modulo-N_REQ wrap.
    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand_s = {1'b0, ptr} + (PW+1)'(i);
            if (cand_s >= (PW+1)'(N_REQ)) begin
                cand_s = cand_s - (PW+1)'(N_REQ);
            end else begin
                cand_s = cand_s;
            end
            if (!any && req[cand_s[PW-1:0]]) begin
                onehot[cand_s[PW-1:0]] = 1'b1;
                idx                    = cand_s[PW-1:0];
                any                    = 1'b1;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding one UART transmitter, one byte at a
// time, with a watchdog that aborts a stalled packet in SEND or WAIT.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int D_BITS         = UART_D_BITS,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      i_clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          i_req_valid,
    input  logic [N_REQ*D_BITS-1:0]   i_req_data,
    input  logic [N_REQ-1:0]          i_req_last,
    output logic [N_REQ-1:0]          o_req_ready,
    output logic [N_REQ-1:0]          o_grant,
    output logic                      o_busy,
    output logic                      o_timeout,
    output logic [D_BITS-1:0]         o_tx_data,
    output logic                      o_tx_enable,
    input  logic                      i_tx_rdy,
    input  logic                      i_tx_done
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    uart_state_t       state_r, state_nx_s;
    logic [PW-1:0]     rr_ptr_r, gidx_r, pick_idx_s;
    logic [N_REQ-1:0]  grant_r, pick_onehot_s;
    logic              pick_any_s;
    logic [CW-1:0]     cnt_r;
    logic              last_r, tx_enable_r, busy_r, timeout_r;
    logic [D_BITS-1:0] tx_data_r;
    logic              pop_s, done_s, expire_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_rr_pick (
        .req    (i_req_valid),
        .ptr    (rr_ptr_r),
        .onehot (pick_onehot_s),
        .idx    (pick_idx_s),
        .any    (pick_any_s)
    );

    // Next-state decode; a completing i_tx_done takes priority over the watchdog.
    always_comb begin
        state_nx_s = state_r;
        pop_s      = 1'b0;
        done_s     = 1'b0;
        expire_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_any_s) begin
                    state_nx_s = ST_SEND;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (i_req_valid[gidx_r] && i_tx_rdy) begin
                    pop_s      = 1'b1;
                    state_nx_s = ST_START;
                end else if (cnt_r == CNT_LAST) begin
                    expire_s   = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SEND;
                end
            end
            ST_START: begin
                state_nx_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_tx_done) begin
                    done_s     = 1'b1;
                    state_nx_s = last_r ? ST_IDLE : ST_SEND;
                end else if (cnt_r == CNT_LAST) begin
                    expire_s   = 1'b1;
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Pop strobe is combinational so the byte leaves the producer in the SEND cycle.
    always_comb begin
        if (pop_s) begin
            o_req_ready = grant_r;
        end else begin
            o_req_ready = '0;
        end
    end

    // State, watchdog and transmitter-side registers.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            busy_r      <= 1'b0;
            tx_enable_r <= 1'b0;
            timeout_r   <= 1'b0;
            tx_data_r   <= '0;
            last_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            busy_r      <= (state_nx_s != ST_IDLE);
            tx_enable_r <= pop_s;
            timeout_r   <= expire_s;
            if (state_nx_s != state_r) begin
                cnt_r <= '0;
            end else if ((state_r == ST_SEND) || (state_r == ST_WAIT)) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= '0;
            end
            if (pop_s) begin
                tx_data_r <= i_req_data[gidx_r*D_BITS +: D_BITS];
                last_r    <= i_req_last[gidx_r];
            end else begin
                tx_data_r <= tx_data_r;
                last_r    <= last_r;
            end
        end
    end

    // Grant ownership and rotation; the pointer advances past the owner on every release.
    always_ff @(posedge i_clk or negedge reset) begin
        if (!reset) begin
            grant_r  <= '0;
            gidx_r   <= '0;
            rr_ptr_r <= '0;
        end else begin
            if ((state_r == ST_IDLE) && pick_any_s) begin
                grant_r <= pick_onehot_s;
                gidx_r  <= pick_idx_s;
            end else if ((done_s && last_r) || expire_s) begin
                grant_r  <= '0;
                rr_ptr_r <= PW'(rr_next(32'(gidx_r), 32'(N_REQ)));
            end else begin
                grant_r  <= grant_r;
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    assign o_grant     = grant_r;
    assign o_busy      = busy_r;
    assign o_timeout   = timeout_r;
    assign o_tx_data   = tx_data_r;
    assign o_tx_enable = tx_enable_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter and
// per-requester byte-stream producers.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int DB   = 8;
    localparam int TO   = 4096;
    localparam int CHAR = 20;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      i_req_valid;
    logic [N*DB-1:0]   i_req_data;
    logic [N-1:0]      i_req_last;
    logic [N-1:0]      o_req_ready;
    logic [N-1:0]      o_grant;
    logic              o_busy;
    logic              o_timeout;
    logic [DB-1:0]     o_tx_data;
    logic              o_tx_enable;
    logic              i_tx_rdy;
    logic              i_tx_done;

    logic              tx_busy, model_done, force_done, withhold, tx_release;
    int                tcnt;

    logic [8:0]        stim [N][32];
    int                stim_wr [N];
    int                stim_rd [N];
    logic [N-1:0]      take;

    logic [7:0]        tx_log[$];
    int                grant_log[$];
    logic [N-1:0]      prev_grant;
    int                enable_cnt, timeout_cnt, proto_viol;
    int                cyc, en_cyc, to_cyc, done_cyc;

    int                tests_run, tests_failed;

    always #5 clk = ~clk;

    assign i_tx_rdy  = !tx_busy;
    assign i_tx_done = model_done | force_done;

    uart_tx_arbiter #(
        .N_REQ          (N),
        .D_BITS         (DB),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk       (clk),
        .reset       (reset),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_grant     (o_grant),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout),
        .o_tx_data   (o_tx_data),
        .o_tx_enable (o_tx_enable),
        .i_tx_rdy    (i_tx_rdy),
        .i_tx_done   (i_tx_done)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: accepts on enable&rdy, pulses done CHAR cycles later.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_busy    <= 1'b0;
            model_done <= 1'b0;
            tcnt       <= 0;
        end else begin
            model_done <= 1'b0;
            if (tx_release) begin
                tx_busy <= 1'b0;
            end else if (o_tx_enable && !tx_busy) begin
                tx_log.push_back(o_tx_data);
                tx_busy <= 1'b1;
                tcnt    <= CHAR;
            end else if (tx_busy && !withhold) begin
                if (tcnt == 1) begin
                    tx_busy    <= 1'b0;
                    model_done <= 1'b1;
                end
                tcnt <= tcnt - 1;
            end
        end
    end

    // Producers: pop on valid&ready seen before the edge, re-present the head after it.
    initial begin
        i_req_valid = '0;
        i_req_data  = '0;
        i_req_last  = '0;
        take        = '0;
        for (int k = 0; k < N; k++) stim_rd[k] = 0;
        forever begin
            @(negedge clk);
            take = i_req_valid & o_req_ready;
            @(posedge clk);
            #1;
            for (int k = 0; k < N; k++) begin
                if (take[k] && (stim_rd[k] < stim_wr[k])) stim_rd[k] = stim_rd[k] + 1;
                if (stim_rd[k] < stim_wr[k]) begin
                    i_req_valid[k]         = 1'b1;
                    i_req_data[k*DB +: DB] = stim[k][stim_rd[k]][7:0];
                    i_req_last[k]          = stim[k][stim_rd[k]][8];
                end else begin
                    i_req_valid[k] = 1'b0;
                    i_req_last[k]  = 1'b0;
                end
            end
        end
    end

    // Protocol monitor and event logs.
    initial begin
        enable_cnt = 0; timeout_cnt = 0; proto_viol = 0;
        en_cyc = 0; to_cyc = 0; done_cyc = 0; prev_grant = '0;
        forever begin
            @(negedge clk);
            if (o_tx_enable) begin
                enable_cnt = enable_cnt + 1;
                en_cyc     = cyc;
                if (!i_tx_rdy) proto_viol = proto_viol + 1;
            end
            if ((o_req_ready & ~o_grant) != '0) proto_viol = proto_viol + 1;
            if ($countones(o_grant) > 1) proto_viol = proto_viol + 1;
            if (o_timeout) begin
                timeout_cnt = timeout_cnt + 1;
                to_cyc      = cyc;
            end
            if (i_tx_done) done_cyc = cyc;
            if ((o_grant != '0) && (o_grant != prev_grant)) begin
                for (int k = 0; k < N; k++) if (o_grant[k]) grant_log.push_back(k + 1);
            end
            prev_grant = o_grant;
        end
    end

    function automatic logic [63:0] pack_tx(input int base);
        logic [63:0] r = '0;
        for (int i = base; i < tx_log.size(); i++) r = {r[55:0], tx_log[i]};
        return r;
    endfunction

    function automatic logic [15:0] pack_grants(input int base);
        logic [15:0] r = '0;
        for (int i = base; i < grant_log.size(); i++) r = {r[11:0], 4'(grant_log[i])};
        return r;
    endfunction

    task automatic push(input int k, input logic last, input logic [7:0] d);
        stim[k][stim_wr[k]] = {last, d};
        stim_wr[k] = stim_wr[k] + 1;
    endtask

    task automatic wait_quiet(input int maxc, output bit ok);
        bit pend;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            pend = 1'b0;
            for (int k = 0; k < N; k++) if (stim_rd[k] != stim_wr[k]) pend = 1'b1;
            if (!pend && !o_busy && (!tx_busy || withhold)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic release_tx();
        tx_release = 1'b1;
        @(posedge clk);
        #1;
        tx_release = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({o_req_ready, o_grant, o_busy, o_timeout, o_tx_data, o_tx_enable} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got rdy=%b gnt=%b busy=%b to=%b data=%h en=%b, expected all 0",
                     o_req_ready, o_grant, o_busy, o_timeout, o_tx_data, o_tx_enable);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({o_grant, o_busy} !== '0) begin
            tests_failed++;
            $display("FAIL idle_no_req: got gnt=%b busy=%b, expected 0", o_grant, o_busy);
        end
    endtask

    task automatic test_tie();
        int tb0, gb0; bit ok;
        tb0 = tx_log.size(); gb0 = grant_log.size();
        push(0, 1'b0, 8'h10); push(0, 1'b1, 8'h11); push(2, 1'b1, 8'h20);
        wait_quiet(600, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL tie_done: got busy after 600 cycles, expected idle"); end
        tests_run++;
        if (pack_tx(tb0) !== 64'h0000_0000_0010_1120) begin
            tests_failed++; $display("FAIL tie_bytes: got %h expected 101120", pack_tx(tb0));
        end
        tests_run++;
        if (pack_grants(gb0) !== 16'h0013) begin
            tests_failed++; $display("FAIL tie_order: got %h expected 0013", pack_grants(gb0));
        end
        tb0 = tx_log.size(); gb0 = grant_log.size();
        push(1, 1'b1, 8'h31); push(2, 1'b1, 8'h32);
        wait_quiet(600, ok);
        tests_run++;
        if (!ok || pack_grants(gb0) !== 16'h0023 || pack_tx(tb0) !== 64'h3132) begin
            tests_failed++;
            $display("FAIL tie_rotate: got grants %h bytes %h ok=%0d, expected 0023 3132 1",
                     pack_grants(gb0), pack_tx(tb0), ok);
        end
    endtask

    task automatic test_single_packet();
        int tb0, gb0, e0, p0, t0; bit ok;
        tb0 = tx_log.size(); gb0 = grant_log.size();
        e0 = enable_cnt; p0 = proto_viol; t0 = timeout_cnt;
        push(1, 1'b0, 8'hA5); push(1, 1'b0, 8'h5A); push(1, 1'b1, 8'hFF);
        wait_quiet(600, ok);
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL single_done: got busy after 600 cycles, expected idle"); end
        tests_run++;
        if (enable_cnt - e0 !== 3) begin
            tests_failed++; $display("FAIL single_enables: got %0d expected 3", enable_cnt - e0);
        end
        tests_run++;
        if (pack_tx(tb0) !== 64'h0000_0000_00A5_5AFF) begin
            tests_failed++; $display("FAIL single_bytes: got %h expected A55AFF", pack_tx(tb0));
        end
        tests_run++;
        if (pack_grants(gb0) !== 16'h0002 || o_grant !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_grant: got log %h final %b, expected 0002 0000", pack_grants(gb0), o_grant);
        end
        tests_run++;
        if (proto_viol != p0 || timeout_cnt != t0) begin
            tests_failed++;
            $display("FAIL single_protocol: got viol %0d timeouts %0d, expected 0 0",
                     proto_viol - p0, timeout_cnt - t0);
        end
    endtask

    task automatic test_packet_lock();
        int tb0, gb0, e0, p0; bit ok;
        tb0 = tx_log.size(); gb0 = grant_log.size(); e0 = enable_cnt; p0 = proto_viol;
        push(3, 1'b0, 8'h30); push(3, 1'b0, 8'h31); push(3, 1'b0, 8'h32); push(3, 1'b1, 8'h33);
        for (int i = 0; i < 200 && enable_cnt == e0; i++) @(negedge clk);
        tests_run++;
        if (enable_cnt == e0) begin tests_failed++; $display("FAIL lock_start: got no enable, expected one"); end
        push(0, 1'b1, 8'h40);
        wait_quiet(1000, ok);
        tests_run++;
        if (!ok || pack_tx(tb0) !== 64'h0000_0030_3132_3340) begin
            tests_failed++; $display("FAIL lock_bytes: got %h ok=%0d expected 3031323340", pack_tx(tb0), ok);
        end
        tests_run++;
        if (pack_grants(gb0) !== 16'h0041 || proto_viol != p0) begin
            tests_failed++;
            $display("FAIL lock_grant: got %h viol %0d expected 0041 0", pack_grants(gb0), proto_viol - p0);
        end
    endtask

    task automatic test_timeout_send();
        int tb0, gb0, t0; bit ok;
        tb0 = tx_log.size(); gb0 = grant_log.size(); t0 = timeout_cnt;
        push(1, 1'b0, 8'h11);
        wait_quiet(TO + 500, ok);
        tests_run++;
        if (!ok || timeout_cnt - t0 !== 1) begin
            tests_failed++; $display("FAIL send_timeout: got %0d pulses ok=%0d expected 1", timeout_cnt - t0, ok);
        end
        tests_run++;
        if (to_cyc - done_cyc !== TO + 1) begin
            tests_failed++; $display("FAIL send_timeout_delay: got %0d expected %0d", to_cyc - done_cyc, TO + 1);
        end
        tests_run++;
        if (pack_tx(tb0) !== 64'h11 || o_grant !== 4'b0000 || pack_grants(gb0) !== 16'h0002) begin
            tests_failed++;
            $display("FAIL send_timeout_state: got bytes %h gnt %b log %h expected 11 0000 0002",
                     pack_tx(tb0), o_grant, pack_grants(gb0));
        end
        gb0 = grant_log.size(); tb0 = tx_log.size();
        push(1, 1'b1, 8'h21); push(2, 1'b1, 8'h22);
        wait_quiet(600, ok);
        tests_run++;
        if (!ok || pack_grants(gb0) !== 16'h0032 || pack_tx(tb0) !== 64'h2221) begin
            tests_failed++;
            $display("FAIL timeout_ptr: got grants %h bytes %h expected 0032 2221", pack_grants(gb0), pack_tx(tb0));
        end
    endtask

    task automatic test_timeout_wait();
        int t0, gb0, e0; bit ok;
        t0 = timeout_cnt;
        withhold = 1'b1;
        push(0, 1'b1, 8'h55);
        wait_quiet(TO + 500, ok);
        tests_run++;
        if (!ok || timeout_cnt - t0 !== 1 || o_grant !== 4'b0000) begin
            tests_failed++;
            $display("FAIL wait_timeout: got %0d pulses gnt %b ok=%0d expected 1 0000 1", timeout_cnt - t0, o_grant, ok);
        end
        tests_run++;
        if (to_cyc - en_cyc !== TO + 1) begin
            tests_failed++; $display("FAIL wait_timeout_delay: got %0d expected %0d", to_cyc - en_cyc, TO + 1);
        end
        release_tx();
        t0 = timeout_cnt; gb0 = grant_log.size(); e0 = enable_cnt;
        push(1, 1'b1, 8'h66);
        for (int i = 0; i < 200 && enable_cnt == e0; i++) @(negedge clk);
        for (int i = 0; i < TO + 100 && cyc != en_cyc + TO; i++) begin
            @(posedge clk);
            #1;
        end
        tests_run++;
        if (cyc != en_cyc + TO) begin
            tests_failed++; $display("FAIL done_wins_align: got cycle %0d expected %0d", cyc, en_cyc + TO);
        end
        force_done = 1'b1;
        @(posedge clk);
        #1;
        force_done = 1'b0;
        wait_quiet(100, ok);
        tests_run++;
        if (!ok || timeout_cnt != t0 || o_busy !== 1'b0 || pack_grants(gb0) !== 16'h0002) begin
            tests_failed++;
            $display("FAIL done_wins: got %0d pulses busy %b log %h expected 0 0 0002",
                     timeout_cnt - t0, o_busy, pack_grants(gb0));
        end
        release_tx();
        withhold = 1'b0;
    endtask

    task automatic test_reset_mid();
        int tb0, gb0, e0; bit ok;
        e0 = enable_cnt;
        push(2, 1'b0, 8'h77); push(2, 1'b1, 8'h78);
        for (int i = 0; i < 200 && enable_cnt == e0; i++) @(negedge clk);
        repeat (3) @(posedge clk);
        #3;
        tests_run++;
        if (o_busy !== 1'b1 || o_grant !== 4'b0100) begin
            tests_failed++; $display("FAIL pre_reset: got busy %b gnt %b expected 1 0100", o_busy, o_grant);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({o_req_ready, o_grant, o_busy, o_timeout, o_tx_data, o_tx_enable} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got gnt=%b busy=%b data=%h en=%b expected all 0",
                     o_grant, o_busy, o_tx_data, o_tx_enable);
        end
        tb0 = tx_log.size(); gb0 = grant_log.size();
        push(1, 1'b1, 8'h81); push(3, 1'b1, 8'h83);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_quiet(1000, ok);
        tests_run++;
        if (!ok || pack_grants(gb0) !== 16'h0234 || pack_tx(tb0) !== 64'h81_7883) begin
            tests_failed++;
            $display("FAIL post_reset_ptr: got grants %h bytes %h expected 0234 817883", pack_grants(gb0), pack_tx(tb0));
        end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        withhold = 1'b0; force_done = 1'b0; tx_release = 1'b0;
        for (int k = 0; k < N; k++) stim_wr[k] = 0;
        test_reset();
        test_tie();
        test_single_packet();
        test_packet_lock();
        test_timeout_send();
        test_timeout_wait();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        cyc = 0;
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
